// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared datapath constants and forwarding select encodings.
package hazard_scoreboard_pkg;
  localparam int WORD = 32;
  localparam int REG_AW = 5;
  localparam int SEL_RF = 0;
  localparam int SEL_EX = 1;
  localparam int SEL_MEM = 2;
  localparam int SEL_WB = 3;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage operand description in, stall/forward selects out.
interface hazard_scoreboard_if #(
  parameter int FWD_STAGES = 3,
  parameter int REG_AW = hazard_scoreboard_pkg::REG_AW,
  parameter int SW = $clog2(FWD_STAGES + 1)
);
  logic freeze;
  logic flush;
  logic id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic id_use_rs;
  logic id_use_rt;
  logic id_is_branch;
  logic id_wb_en;
  logic id_mem_r;
  logic [REG_AW-1:0] id_dest;
  logic stall;
  logic [SW-1:0] sel_rs;
  logic [SW-1:0] sel_rt;
  logic [15:0] stall_cnt;
  modport master (
    output freeze, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_is_branch, id_wb_en, id_mem_r, id_dest,
    input  stall, sel_rs, sel_rt, stall_cnt
  );
  modport slave (
    input  freeze, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_is_branch, id_wb_en, id_mem_r, id_dest,
    output stall, sel_rs, sel_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_fwd_match.sv
// fwd_match: youngest-producer lookup of one source register over the tag entries.
module fwd_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int N = 3,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW = hazard_scoreboard_pkg::REG_AW,
  parameter int SW = $clog2(N + 1)
) (
  input  logic [REG_AW-1:0]        src,
  input  logic                     use_src,
  input  logic [N:1]               valid,
  input  logic [N:1]               wb_en,
  input  logic [N:1]               mem_r,
  input  logic [N:1][REG_AW-1:0]   dest,
  output logic [SW-1:0]            sel,
  output logic                     load_pend
);
  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel = SW'(SEL_RF);
    load_pend = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (use_src && src != '0 && valid[k] && wb_en[k] && dest[k] == src) begin
        sel = SW'(k);
        load_pend = mem_r[k] && (k <= LOAD_LAT);
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination tags, drives operand forwarding
// selects and the load-use / branch stall for the ID stage.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_EX_FWD = 1,
  parameter int REG_AW = hazard_scoreboard_pkg::REG_AW,
  parameter int SW = $clog2(FWD_STAGES + 1)
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave hz
);
  localparam int N = FWD_STAGES;
  logic [N:1] t_valid, t_wb, t_mem;
  logic [N:1][REG_AW-1:0] t_dest;
  logic [SW-1:0] raw_rs, raw_rt;
  logic pend_rs, pend_rt, br_hold, stall, take;
  logic [15:0] cnt;
  fwd_match #(.N(N), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW), .SW(SW)) u_rs (
    .src(hz.id_rs), .use_src(hz.id_use_rs), .valid(t_valid), .wb_en(t_wb),
    .mem_r(t_mem), .dest(t_dest), .sel(raw_rs), .load_pend(pend_rs)
  );
  fwd_match #(.N(N), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW), .SW(SW)) u_rt (
    .src(hz.id_rt), .use_src(hz.id_use_rt), .valid(t_valid), .wb_en(t_wb),
    .mem_r(t_mem), .dest(t_dest), .sel(raw_rt), .load_pend(pend_rt)
  );
  // A squashed or empty ID slot never stalls; a stalled slot must not forward.
  always_comb begin
    br_hold = hz.id_is_branch && (BR_EX_FWD == 0) &&
              (raw_rs == SW'(SEL_EX) || raw_rt == SW'(SEL_EX));
    stall = hz.id_valid && !hz.flush && (pend_rs || pend_rt || br_hold);
    take = hz.id_valid && !hz.flush && !stall;
    hz.stall = stall;
    hz.sel_rs = stall ? SW'(SEL_RF) : raw_rs;
    hz.sel_rt = stall ? SW'(SEL_RF) : raw_rt;
    hz.stall_cnt = cnt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_valid <= '0;
      t_wb <= '0;
      t_mem <= '0;
      t_dest <= '0;
      cnt <= '0;
    end else if (!hz.freeze) begin
      t_valid <= {t_valid[N-1:1], take};
      t_wb <= {t_wb[N-1:1], hz.id_wb_en};
      t_mem <= {t_mem[N-1:1], hz.id_mem_r};
      t_dest <= {t_dest[N-1:1], hz.id_dest};
      if (stall) cnt <= sat_inc(cnt);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus freeze, flush, saturation and reset sequences.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_s = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.FWD_STAGES(3)) bus ();
  hazard_scoreboard_if #(.FWD_STAGES(3)) bbus ();
  hazard_scoreboard_if #(.FWD_STAGES(6)) sbus ();

  hazard_scoreboard #(.FWD_STAGES(3), .LOAD_LAT(1), .BR_EX_FWD(1)) dut (
    .clk(clk), .rst(rst), .hz(bus.slave));
  hazard_scoreboard #(.FWD_STAGES(3), .LOAD_LAT(1), .BR_EX_FWD(0)) dut_br (
    .clk(clk), .rst(rst), .hz(bbus.slave));
  hazard_scoreboard #(.FWD_STAGES(6), .LOAD_LAT(5), .BR_EX_FWD(1)) dut_sat (
    .clk(clk), .rst(rst_s), .hz(sbus.slave));

  assign bbus.freeze = bus.freeze;
  assign bbus.flush = bus.flush;
  assign bbus.id_valid = bus.id_valid;
  assign bbus.id_rs = bus.id_rs;
  assign bbus.id_rt = bus.id_rt;
  assign bbus.id_use_rs = bus.id_use_rs;
  assign bbus.id_use_rt = bus.id_use_rt;
  assign bbus.id_is_branch = bus.id_is_branch;
  assign bbus.id_wb_en = bus.id_wb_en;
  assign bbus.id_mem_r = bus.id_mem_r;
  assign bbus.id_dest = bus.id_dest;

  typedef struct {
    logic fl;
    logic [4:0] rs, rt;
    logic urs, urt, br, wb, mr;
    logic [4:0] dst;
    logic st;
    logic [1:0] srs, srt;
    logic bchk, bst;
  } vec_t;
  vec_t vt [17];

  function automatic vec_t mk(logic fl, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic br, logic wb, logic mr, logic [4:0] dst, logic st,
                              logic [1:0] srs, logic [1:0] srt, logic bchk, logic bst);
    vec_t v;
    v.fl = fl; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br;
    v.wb = wb; v.mr = mr; v.dst = dst; v.st = st; v.srs = srs; v.srt = srt;
    v.bchk = bchk; v.bst = bst;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.flush = v.fl; bus.id_valid = 1'b1; bus.id_rs = v.rs; bus.id_rt = v.rt;
    bus.id_use_rs = v.urs; bus.id_use_rt = v.urt; bus.id_is_branch = v.br;
    bus.id_wb_en = v.wb; bus.id_mem_r = v.mr; bus.id_dest = v.dst;
  endtask

  task automatic sdrive(logic ld);
    sbus.id_valid = 1'b1; sbus.id_rs = ld ? 5'd0 : 5'd10; sbus.id_rt = 5'd0;
    sbus.id_use_rs = !ld; sbus.id_use_rt = 1'b0; sbus.id_wb_en = ld;
    sbus.id_mem_r = ld; sbus.id_dest = ld ? 5'd10 : 5'd0;
  endtask

  initial begin
    bus.freeze = 0; bus.flush = 0; bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_use_rs = 0; bus.id_use_rt = 0; bus.id_is_branch = 0; bus.id_wb_en = 0;
    bus.id_mem_r = 0; bus.id_dest = 0;
    sbus.freeze = 0; sbus.flush = 0; sbus.id_valid = 0; sbus.id_rs = 0; sbus.id_rt = 0;
    sbus.id_use_rs = 0; sbus.id_use_rt = 0; sbus.id_is_branch = 0; sbus.id_wb_en = 0;
    sbus.id_mem_r = 0; sbus.id_dest = 0;
    //       fl rs  rt  urs urt br wb mr dst st srs srt bchk bst
    vt[0]  = mk(0, 2,  3,  1, 1, 0, 1, 0, 1,  0, 0, 0, 1, 0);
    vt[1]  = mk(0, 1,  3,  1, 1, 0, 1, 0, 2,  0, 1, 0, 1, 0);
    vt[2]  = mk(0, 1,  2,  1, 1, 0, 1, 0, 7,  0, 2, 1, 1, 0);
    vt[3]  = mk(0, 1,  0,  1, 1, 0, 0, 0, 0,  0, 3, 0, 1, 0);
    vt[4]  = mk(0, 7,  0,  1, 0, 0, 1, 1, 4,  0, 2, 0, 1, 0);
    vt[5]  = mk(0, 4,  4,  1, 1, 0, 1, 0, 5,  1, 0, 0, 1, 1);
    vt[6]  = mk(0, 4,  4,  1, 1, 0, 1, 0, 5,  0, 2, 2, 1, 0);
    vt[7]  = mk(0, 4,  4,  0, 1, 0, 1, 0, 0,  0, 0, 3, 1, 0);
    vt[8]  = mk(0, 0,  5,  1, 1, 0, 0, 0, 0,  0, 0, 2, 1, 0);
    vt[9]  = mk(0, 0,  0,  0, 0, 0, 1, 0, 6,  0, 0, 0, 1, 0);
    vt[10] = mk(0, 0,  0,  0, 0, 0, 1, 0, 9,  0, 0, 0, 1, 0);
    vt[11] = mk(0, 0,  0,  0, 0, 0, 1, 0, 6,  0, 0, 0, 1, 0);
    vt[12] = mk(0, 6,  9,  1, 1, 1, 0, 0, 0,  0, 1, 2, 1, 1);
    vt[13] = mk(0, 6,  9,  1, 1, 1, 0, 0, 0,  0, 2, 3, 1, 0);
    vt[14] = mk(0, 0,  0,  0, 0, 0, 1, 1, 8,  0, 0, 0, 0, 0);
    vt[15] = mk(1, 8,  0,  1, 0, 0, 1, 0, 11, 0, 1, 0, 0, 0);
    vt[16] = mk(0, 8,  0,  1, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0);

    #2;
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset sel_rs", 32'(bus.sel_rs), 0);
    chk("reset cnt", 32'(bus.stall_cnt), 0);
    @(negedge clk); rst = 1'b1; rst_s = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("row%0d stall", i), 32'(bus.stall), 32'(vt[i].st));
      chk($sformatf("row%0d sel_rs", i), 32'(bus.sel_rs), 32'(vt[i].srs));
      chk($sformatf("row%0d sel_rt", i), 32'(bus.sel_rt), 32'(vt[i].srt));
      if (vt[i].bchk) begin
        chk($sformatf("row%0d br stall", i), 32'(bbus.stall), 32'(vt[i].bst));
        chk($sformatf("row%0d br sel_rs", i), 32'(bbus.sel_rs), vt[i].bst ? 0 : 32'(vt[i].srs));
      end
    end
    @(negedge clk);
    chk("cnt after table", 32'(bus.stall_cnt), 1);
    chk("br cnt after table", 32'(bbus.stall_cnt), 2);

    drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.freeze = 1'b1;
    #1 chk("frz stall0", 32'(bus.stall), 1);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk); #1;
      chk($sformatf("frz%0d stall", j), 32'(bus.stall), 1);
      chk($sformatf("frz%0d cnt", j), 32'(bus.stall_cnt), 1);
    end
    bus.freeze = 1'b0;
    @(negedge clk); #1;
    chk("unfrz stall", 32'(bus.stall), 0);
    chk("unfrz sel_rs", 32'(bus.sel_rs), 2);
    chk("unfrz cnt", 32'(bus.stall_cnt), 2);

    for (int g = 0; g < 13108; g++) begin
      @(negedge clk);
      if (g == 1) chk("sat group cnt", 32'(sbus.stall_cnt), 5);
      sdrive(1'b1);
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        sdrive(1'b0);
        #1;
        if (g == 0 && j == 4) chk("sat k5 stall", 32'(sbus.stall), 1);
      end
    end
    @(negedge clk);
    sdrive(1'b0);
    #1;
    chk("sat k6 stall", 32'(sbus.stall), 0);
    chk("sat k6 sel", 32'(sbus.sel_rs), 6);
    chk("sat cnt", 32'(sbus.stall_cnt), 32'hFFFF);
    @(negedge clk); sdrive(1'b1);
    @(negedge clk); sdrive(1'b0);
    @(negedge clk); #1;
    chk("sat hold stall", 32'(sbus.stall), 1);
    chk("sat no wrap", 32'(sbus.stall_cnt), 32'hFFFF);
    #1 rst_s = 1'b0;
    #1;
    chk("rst stall", 32'(sbus.stall), 0);
    chk("rst cnt", 32'(sbus.stall_cnt), 0);
    chk("rst sel", 32'(sbus.sel_rs), 0);
    @(negedge clk); rst_s = 1'b1;
    #1 chk("post rst stall", 32'(sbus.stall), 0);
    @(negedge clk); #1;
    chk("post rst cnt", 32'(sbus.stall_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
